// File: rtl/i2c_scl_gen_pkg.sv
// Shared definitions for the I2C SCL generator: command codes, FSM state
// encodings, sequence types and a small command-to-sequence helper.
package i2c_scl_gen_pkg;

    // Command codes presented on cmd
    localparam logic [1:0] CMD_START   = 2'b00;
    localparam logic [1:0] CMD_XFER    = 2'b01;
    localparam logic [1:0] CMD_STOP    = 2'b10;
    localparam logic [1:0] CMD_RESTART = 2'b11;

    // FSM state encodings, visible on state_out
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_S_HIGH    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_LOW       = 3'd3,
        ST_WAIT_HIGH = 3'd4,
        ST_HIGH      = 3'd5
    } state_e;

    // Which bus sequence the LOW/WAIT_HIGH/HIGH phases belong to
    typedef enum logic [1:0] {
        SEQ_XFER    = 2'd0,
        SEQ_RESTART = 2'd1,
        SEQ_STOP    = 2'd2
    } seq_e;

    // Wait cycles after SCL release beyond which the slave is stretching
    localparam int unsigned STRETCH_MIN_WAIT = 32'd3;

    // Map a command accepted in HOLD to the sequence it starts.
    // START while the bus is owned is treated as a repeated start.
    function automatic seq_e seq_of_cmd(input logic [1:0] c);
        seq_e s;
        case (c)
            CMD_XFER: s = SEQ_XFER;
            CMD_STOP: s = SEQ_STOP;
            default:  s = SEQ_RESTART;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Generic two-flop synchroniser with a configurable reset level.
// Used for the SCL pad input; equally usable for SDA.
module i2c_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous pad level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// Command-driven I2C SCL generator. The master FSM issues START, XFER,
// RESTART and STOP through a valid/ready handshake; this block drives the
// open-drain SCL enable, detects slave clock stretching (with an optional
// timeout) and emits mid-phase strobes that pace the SDA block.
// All outputs are registers so scl_oe cannot glitch.
module i2c_scl_gen
    import i2c_scl_gen_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = 32'd20,
    parameter int unsigned BITS_PER_XFER   = 32'd9,
    parameter int unsigned STRETCH_TIMEOUT = 32'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       done,
    input  logic       scl_in,
    output logic       scl_oe,
    output logic       sda_set,
    output logic       sda_sample,
    output logic [3:0] bit_idx,
    output logic [2:0] state_out,
    output logic       stretch,
    output logic       timeout
);

    // One counter serves both the half-period timer and the stretch wait,
    // so it is sized for the larger of the two limits.
    localparam int unsigned CNT_MAX = (HALF_PERIOD > STRETCH_TIMEOUT) ? HALF_PERIOD : STRETCH_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 32'd1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       HP_LAST  = cnt_t'(HALF_PERIOD - 32'd1);
    localparam cnt_t       HP_MID   = cnt_t'(HALF_PERIOD / 32'd2);
    localparam bit         TO_EN    = (STRETCH_TIMEOUT != 32'd0);
    localparam cnt_t       TO_LAST  = cnt_t'(TO_EN ? (STRETCH_TIMEOUT - 32'd1) : 32'd0);
    localparam cnt_t       STR_MIN  = cnt_t'(STRETCH_MIN_WAIT);
    localparam cnt_t       CNT_SAT  = {CNT_W{1'b1}};
    localparam logic [3:0] BIT_LAST = 4'(BITS_PER_XFER - 32'd1);

    state_e     state_q,      state_d;
    seq_e       seq_q,        seq_d;
    cnt_t       cnt_q,        cnt_d;
    logic [3:0] bit_idx_q,    bit_idx_d;
    logic       scl_oe_q,     scl_oe_d;
    logic       done_q,       done_d;
    logic       sda_set_q,    sda_set_d;
    logic       sda_sample_q, sda_sample_d;
    logic       stretch_q,    stretch_d;
    logic       timeout_q,    timeout_d;
    logic       cmd_ready_q,  cmd_ready_d;

    logic scl_s;
    logic accept;

    i2c_sync2 #(
        .RESET_VAL (1'b1)
    ) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (scl_in),
        .q_o   (scl_s)
    );

    assign accept = cmd_valid & cmd_ready_q;

    // Next-state logic; outputs are decoded from the next state so that the
    // registered copies line up with state_q.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        cnt_d     = '0;
        bit_idx_d = bit_idx_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    timeout_d = 1'b0;
                    if (cmd == CMD_START) begin
                        state_d = ST_S_HIGH;
                    end else begin
                        // Bus not owned: nothing to do, just acknowledge
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_S_HIGH: begin
                if (cnt_q == HP_LAST) begin
                    state_d = ST_HOLD;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_HOLD: begin
                if (accept) begin
                    timeout_d = 1'b0;
                    state_d   = ST_LOW;
                    bit_idx_d = 4'd0;
                    seq_d     = seq_of_cmd(cmd);
                end else begin
                    state_d = ST_HOLD;
                end
            end

            ST_LOW: begin
                if (cnt_q == HP_LAST) begin
                    state_d = ST_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_WAIT_HIGH: begin
                // SCL seen high wins over a timeout in the same cycle
                if (scl_s) begin
                    state_d = ST_HIGH;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + cnt_t'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end

            ST_HIGH: begin
                if (cnt_q == HP_LAST) begin
                    case (seq_q)
                        SEQ_XFER: begin
                            if (bit_idx_q == BIT_LAST) begin
                                state_d = ST_HOLD;
                                done_d  = 1'b1;
                            end else begin
                                state_d   = ST_LOW;
                                bit_idx_d = bit_idx_q + 4'd1;
                            end
                        end
                        SEQ_RESTART: begin
                            state_d = ST_HOLD;
                            done_d  = 1'b1;
                        end
                        SEQ_STOP: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        scl_oe_d     = (state_d == ST_HOLD) || (state_d == ST_LOW);
        cmd_ready_d  = (state_d == ST_IDLE) || (state_d == ST_HOLD);
        stretch_d    = (state_d == ST_WAIT_HIGH) && (cnt_d >= STR_MIN);
        sda_set_d    = (cnt_d == HP_MID) &&
                       ((state_d == ST_S_HIGH) || (state_d == ST_LOW) ||
                        ((state_d == ST_HIGH) && (seq_d != SEQ_XFER)));
        sda_sample_d = (cnt_d == HP_MID) && (state_d == ST_HIGH) && (seq_d == SEQ_XFER);
    end

    // State and registered outputs; reset aborts any command and releases SCL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            seq_q        <= SEQ_XFER;
            cnt_q        <= '0;
            bit_idx_q    <= 4'd0;
            scl_oe_q     <= 1'b0;
            done_q       <= 1'b0;
            sda_set_q    <= 1'b0;
            sda_sample_q <= 1'b0;
            stretch_q    <= 1'b0;
            timeout_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            scl_oe_q     <= scl_oe_d;
            done_q       <= done_d;
            sda_set_q    <= sda_set_d;
            sda_sample_q <= sda_sample_d;
            stretch_q    <= stretch_d;
            timeout_q    <= timeout_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign done       = done_q;
    assign scl_oe     = scl_oe_q;
    assign sda_set    = sda_set_q;
    assign sda_sample = sda_sample_q;
    assign bit_idx    = bit_idx_q;
    assign state_out  = state_q;
    assign stretch    = stretch_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: a main instance (HALF_PERIOD=20, ideal SCL loopback
// with an injectable slave hold) checked through an expectation queue, and a
// second instance with STRETCH_TIMEOUT=50 whose SCL never rises.
module tb_i2c_scl_gen;
    import i2c_scl_gen_pkg::*;

    typedef struct {
        int         acc;      // posedge at which the command is accepted
        int         lat;      // posedges from accept to the edge raising done
        logic [2:0] st;
        logic       oe;
        logic [3:0] bidx;
        logic       to;
        int         sets;
        int         samples;
        int         rises;
        int         falls;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cmd_valid, cmd_ready, done, scl_in, scl_oe, sda_set, sda_sample, stretch, timeout;
    logic [1:0] cmd;
    logic [3:0] bit_idx;
    logic [2:0] state_out;
    logic       hold;

    logic       t_valid, t_ready, t_done, t_scl_oe, t_set, t_sample, t_stretch, t_timeout;
    logic [1:0] t_cmd;
    logic [3:0] t_bit_idx;
    logic [2:0] t_state;

    // Ideal open-drain loopback; hold models a slave stretching SCL
    assign scl_in = scl_oe ? 1'b0 : ~hold;

    i2c_scl_gen #(.HALF_PERIOD(20), .BITS_PER_XFER(9), .STRETCH_TIMEOUT(1000)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .done(done), .scl_in(scl_in), .scl_oe(scl_oe), .sda_set(sda_set),
        .sda_sample(sda_sample), .bit_idx(bit_idx), .state_out(state_out),
        .stretch(stretch), .timeout(timeout)
    );

    i2c_scl_gen #(.HALF_PERIOD(20), .BITS_PER_XFER(9), .STRETCH_TIMEOUT(50)) dut_to (
        .clk(clk), .rst_n(rst_n), .cmd_valid(t_valid), .cmd(t_cmd), .cmd_ready(t_ready),
        .done(t_done), .scl_in(1'b0), .scl_oe(t_scl_oe), .sda_set(t_set),
        .sda_sample(t_sample), .bit_idx(t_bit_idx), .state_out(t_state),
        .stretch(t_stretch), .timeout(t_timeout)
    );

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [2:0] st, input logic oe,
                                input logic [3:0] bidx, input logic to, input int sets,
                                input int samples, input int rises, input int falls);
        exp_t e;
        e.acc = 0; e.lat = lat; e.st = st; e.oe = oe; e.bidx = bidx; e.to = to;
        e.sets = sets; e.samples = samples; e.rises = rises; e.falls = falls;
        return e;
    endfunction

    // Offer a command to the main instance and queue its expected outcome
    task automatic send(input logic [1:0] c, input exp_t e);
        int b = 0;
        @(negedge clk);
        while (!cmd_ready && b < 2000) begin
            @(negedge clk);
            b++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("queue_drain", exp_q.size(), 0);
    endtask

    // Offer a command to the timeout instance (always idle or holding here)
    task automatic send_t(input logic [1:0] c);
        @(negedge clk);
        t_valid = 1'b1;
        t_cmd   = c;
        @(negedge clk);
        t_valid = 1'b0;
    endtask

    task automatic wait_done_t(output int lat, output logic saw_stretch);
        lat = 0;
        saw_stretch = 1'b0;
        while (!t_done && lat < 300) begin
            if (t_stretch) saw_stretch = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    // Monitor: tracks strobes/SCL edges per command and scores each done
    initial begin
        int         ph = 0, sets = 0, samples = 0, rises = 0, falls = 0;
        logic [2:0] prev_st = ST_IDLE;
        logic       prev_oe = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ph = 0; sets = 0; samples = 0; rises = 0; falls = 0;
                prev_st = ST_IDLE; prev_oe = 1'b0;
            end else begin
                if (state_out != prev_st) ph = 0; else ph++;
                prev_st = state_out;
                if (scl_oe && !prev_oe) rises++;
                if (!scl_oe && prev_oe) falls++;
                prev_oe = scl_oe;
                if (sda_set) begin
                    sets++;
                    chk("sda_set_phase", ph, 10);
                end
                if (sda_sample) begin
                    samples++;
                    chk("sda_sample_phase", ph, 10);
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_expected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency",   cyc - e.acc, e.lat);
                        chk("end_state", state_out, e.st);
                        chk("end_oe",    scl_oe, e.oe);
                        chk("bit_idx",   bit_idx, e.bidx);
                        chk("timeout",   timeout, e.to);
                        chk("n_sda_set", sets, e.sets);
                        chk("n_sample",  samples, e.samples);
                        chk("oe_rises",  rises, e.rises);
                        chk("oe_falls",  falls, e.falls);
                    end
                    sets = 0; samples = 0; rises = 0; falls = 0;
                end
            end
        end
    end

    initial begin
        int   lat;
        int   b;
        logic saw;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; hold = 1'b0;
        t_valid = 1'b0; t_cmd = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_state",   state_out, ST_IDLE);
        chk("rst_oe",      scl_oe, 0);
        chk("rst_done",    done, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_ready",   cmd_ready, 1);
        chk("rst_strobes", {sda_set, sda_sample, stretch}, 0);
        rst_n = 1'b1;

        // Timeout instance: START, XFER with SCL stuck low, then START again
        send_t(CMD_START);
        wait_done_t(lat, saw);
        chk("to_start_lat",   lat, 20);
        chk("to_start_oe",    t_scl_oe, 1);
        chk("to_start_state", t_state, ST_HOLD);
        send_t(CMD_XFER);
        wait_done_t(lat, saw);
        chk("to_xfer_lat",     lat, 70);
        chk("to_flag",         t_timeout, 1);
        chk("to_state",        t_state, ST_IDLE);
        chk("to_oe",           t_scl_oe, 0);
        chk("to_saw_stretch",  saw, 1);
        send_t(CMD_START);
        chk("to_cleared_on_accept", t_timeout, 0);
        wait_done_t(lat, saw);
        chk("to_restart_lat",  lat, 20);
        chk("to_still_clear",  t_timeout, 0);

        // Main instance: illegal command in IDLE
        send(CMD_XFER, mk(0, ST_IDLE, 1'b0, 4'd0, 1'b0, 0, 0, 0, 0));
        chk("illegal_ready_high", cmd_ready, 1);
        chk("illegal_oe_low",     scl_oe, 0);
        drain();

        // START, 9-bit XFER, RESTART, STOP, illegal RESTART
        send(CMD_START,   mk(20,  ST_HOLD, 1'b1, 4'd0, 1'b0, 1, 0, 1, 0));
        send(CMD_XFER,    mk(387, ST_HOLD, 1'b1, 4'd8, 1'b0, 9, 9, 9, 9));
        send(CMD_RESTART, mk(43,  ST_HOLD, 1'b1, 4'd0, 1'b0, 2, 0, 1, 1));
        send(CMD_STOP,    mk(43,  ST_IDLE, 1'b0, 4'd0, 1'b0, 2, 0, 0, 1));
        send(CMD_RESTART, mk(0,   ST_IDLE, 1'b0, 4'd0, 1'b0, 0, 0, 0, 0));
        drain();

        // Slave stretches bit 8 for 100 cycles
        send(CMD_START, mk(20,  ST_HOLD, 1'b1, 4'd0, 1'b0, 1, 0, 1, 0));
        send(CMD_XFER,  mk(487, ST_HOLD, 1'b1, 4'd8, 1'b0, 9, 9, 9, 9));
        b = 0;
        while (!(bit_idx == 4'd8 && state_out == ST_LOW) && b < 1000) begin
            @(negedge clk);
            b++;
        end
        hold = 1'b1;
        b = 0;
        while (state_out != ST_WAIT_HIGH && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("stretch_enter_wait", state_out, ST_WAIT_HIGH);
        for (int k = 0; k < 100; k++) begin
            if (k == 2) chk("stretch_wait2", stretch, 0);
            if (k == 3) chk("stretch_wait3", stretch, 1);
            @(negedge clk);
        end
        hold = 1'b0;
        chk("stretch_still_wait", state_out, ST_WAIT_HIGH);
        repeat (2) @(negedge clk);
        chk("stretch_wait_last", state_out, ST_WAIT_HIGH);
        @(negedge clk);
        chk("stretch_high_start", state_out, ST_HIGH);
        chk("stretch_cleared",    stretch, 0);
        chk("stretch_no_timeout", timeout, 0);
        drain();

        // Reset in the middle of bit 4 of an XFER
        send(CMD_XFER, mk(387, ST_HOLD, 1'b1, 4'd8, 1'b0, 9, 9, 9, 9));
        b = 0;
        while (!(bit_idx == 4'd4 && scl_oe) && b < 1000) begin
            @(negedge clk);
            b++;
        end
        chk("reach_bit4_low", {bit_idx, scl_oe}, {4'd4, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_oe",      scl_oe, 0);
        chk("midrst_state",   state_out, ST_IDLE);
        chk("midrst_bit_idx", bit_idx, 0);
        chk("midrst_timeout", timeout, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
